// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection over a shift pipeline of in-flight register writes.
// Optional STALL_CNT_EN adds a saturating load-use stall counter output (stall_cnt).
module fwd_hazard_unit #(
   parameter int DATA_W     = 16,
   parameter int REG_AW     = 3,
   parameter int NSTAGE     = 3,
   parameter int LOAD_STAGE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic [REG_AW-1:0]        id_rs,
   input  logic [REG_AW-1:0]        id_rt,
   input  logic                     id_use_rs,
   input  logic                     id_use_rt,
   input  logic                     id_wr_en,
   input  logic [REG_AW-1:0]        id_wr_addr,
   input  logic                     id_is_load,
   input  logic [DATA_W-1:0]        rf_data_a,
   input  logic [DATA_W-1:0]        rf_data_b,
   input  logic [NSTAGE*DATA_W-1:0] st_data,
   input  logic                     mem_stall,
   input  logic                     flush,
   output logic [DATA_W-1:0]        fwd_data_a,
   output logic [DATA_W-1:0]        fwd_data_b,
   output logic [3:0]               fwd_sel_a,
   output logic [3:0]               fwd_sel_b,
   output logic                     haz_stall,
`ifdef STALL_CNT_EN
   output logic [15:0]              stall_cnt,
`endif
   output logic                     err
);

   logic [NSTAGE-1:0]             v_q, v_d;
   logic [NSTAGE-1:0]             ld_q, ld_d;
   logic [NSTAGE-1:0][REG_AW-1:0] addr_q, addr_d;
   logic                          stall_a, stall_b;

   // Scan oldest to youngest so the lowest matching entry overwrites older hits.
   always_comb begin
      fwd_sel_a  = '0;
      fwd_data_a = rf_data_a;
      stall_a    = 1'b0;
      for (int k = NSTAGE - 1; k >= 0; k--) begin
         if (v_q[k] && (addr_q[k] == id_rs) && id_use_rs && id_valid) begin
            if (ld_q[k] && (k < LOAD_STAGE)) begin
               stall_a    = 1'b1;
               fwd_sel_a  = '0;
               fwd_data_a = rf_data_a;
            end else begin
               stall_a    = 1'b0;
               fwd_sel_a  = 4'(k + 1);
               fwd_data_a = st_data[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_comb begin
      fwd_sel_b  = '0;
      fwd_data_b = rf_data_b;
      stall_b    = 1'b0;
      for (int k = NSTAGE - 1; k >= 0; k--) begin
         if (v_q[k] && (addr_q[k] == id_rt) && id_use_rt && id_valid) begin
            if (ld_q[k] && (k < LOAD_STAGE)) begin
               stall_b    = 1'b1;
               fwd_sel_b  = '0;
               fwd_data_b = rf_data_b;
            end else begin
               stall_b    = 1'b0;
               fwd_sel_b  = 4'(k + 1);
               fwd_data_b = st_data[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign haz_stall = stall_a | stall_b;
   assign err       = flush & mem_stall;

   // A stalled or flushed issue slot enters the pipeline as a bubble.
   always_comb begin
      v_d    = v_q;
      ld_d   = ld_q;
      addr_d = addr_q;
      if (!mem_stall) begin
         for (int k = NSTAGE - 1; k >= 1; k--) begin
            v_d[k]    = v_q[k-1];
            ld_d[k]   = ld_q[k-1];
            addr_d[k] = addr_q[k-1];
         end
         v_d[0]    = id_valid & id_wr_en & ~haz_stall & ~flush;
         ld_d[0]   = id_is_load;
         addr_d[0] = id_wr_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         v_q    <= '0;
         ld_q   <= '0;
         addr_q <= '0;
      end else begin
         v_q    <= v_d;
         ld_q   <= ld_d;
         addr_q <= addr_d;
      end
   end

`ifdef STALL_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (haz_stall && !mem_stall && (cnt_q != 16'hFFFF))
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign stall_cnt = cnt_q;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined core; replaces the fixed 3-bit/16-bit mux logic in the processor top.
- Owns a shift pipeline of in-flight register writes (one entry per post-decode stage) that advances with the pipeline and freezes on memory stall.
- Selects the youngest matching producer per source operand, or asserts stall when that producer's data is not yet available.

Parameters:
- DATA_W, 16, operand/result width
- REG_AW, 3, register address width (2**REG_AW registers)
- NSTAGE, 3, tracked stages after issue (entry 0 = EX … NSTAGE-1 = WB), range 2..8
- LOAD_STAGE, 1, first entry index holding valid load data, range 1..NSTAGE-1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- id_valid  in  1  consumer instruction present at issue
- id_rs  in  REG_AW  source A address
- id_rt  in  REG_AW  source B address
- id_use_rs  in  1  source A is read
- id_use_rt  in  1  source B is read
- id_wr_en  in  1  consumer writes a register
- id_wr_addr  in  REG_AW  consumer destination
- id_is_load  in  1  consumer is a memory read
- rf_data_a  in  DATA_W  register-file value for id_rs
- rf_data_b  in  DATA_W  register-file value for id_rt
- st_data  in  NSTAGE*DATA_W  result of entry k on bits [k*DATA_W +: DATA_W]
- mem_stall  in  1  whole pipeline frozen this cycle
- flush  in  1  branch/jump taken; drop issuing instruction
- fwd_data_a  out  DATA_W  forwarded source A
- fwd_data_b  out  DATA_W  forwarded source B
- fwd_sel_a  out  4  0 = register file, k+1 = entry k
- fwd_sel_b  out  4  as fwd_sel_a
- haz_stall  out  1  load-use stall request
- err  out  1  protocol violation

Behaviour:
- Entry k holds {v, addr, ld}. Reset (rst==0 at clk edge): all v=0; the combinational outputs then settle to fwd_sel=0, fwd_data=rf_data, haz_stall=0, err=0.
- Match for source A on entry k: v & addr==id_rs & id_use_rs & id_valid. Source B is identical with id_rt/id_use_rt.
- Winner is the lowest matching k (youngest producer). No match gives fwd_sel=0 and fwd_data=rf_data. Register 0 is an ordinary register.
- Winner with ld=1 and k<LOAD_STAGE: haz_stall=1, and fwd_sel/fwd_data take the no-match value. Otherwise fwd_sel=k+1 and fwd_data=st_data slice k.
- haz_stall = OR of both sources' stall conditions. It is purely combinational (zero latency).
- Clock update when rst==1:
  - mem_stall=1: all entries hold, whatever flush or haz_stall are.
  - Otherwise: entry k moves to k+1 and entry NSTAGE-1 retires.
  - Entry 0 loads {id_valid&id_wr_en, id_wr_addr, id_is_load} when ~haz_stall & ~flush; otherwise it loads a bubble (v=0).
- A stalled consumer stays at issue. The producing load advances one entry per cycle, so with LOAD_STAGE=1 the stall lasts exactly 1 cycle.
- Both sources matching different entries resolve independently.
- err=1 combinationally when flush & mem_stall in the same cycle.
- Asserting reset in the middle of a stall or flush clears all entries on that edge.

Optional Feature:
- STALL_CNT_EN defined: adds output stall_cnt[15:0]. It increments on each clock with haz_stall & ~mem_stall, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and the counter do not exist, and all other behaviour is identical.

Test Plan:
- Defaults. ALU write r3 issued, next consumer reads rs=r3 with st_data[0]=16'h1234 -> fwd_sel_a=1, fwd_data_a=16'h1234, haz_stall=0.
- Load to r2 issued, next consumer reads rt=r2 -> haz_stall=1 for exactly 1 cycle. Next cycle fwd_sel_b=2, fwd_data_b=st_data[1].
- Writes r5 at entries 0 and 2 (st_data 16'hAAAA / 16'hCCCC), consumer reads r5 -> youngest wins: fwd_sel_a=1, 16'hAAAA.
- Load r1 in entry 0 with mem_stall=1 held 3 cycles -> entries frozen, haz_stall stays 1. mem_stall drops -> next cycle stall clears, fwd_sel_a=2.
- flush with id_wr_en r4 -> entry 0 becomes a bubble, and a later reader of r4 gets fwd_sel=0. flush & mem_stall together -> err=1.
- STALL_CNT_EN: two load-use stalls -> stall_cnt=2. rst=0 -> stall_cnt=0.
